// File: rtl/alu_pkg.sv
// Shared types for the multi-cycle ALU: opcode enum, FSM states, flag bundle.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'h0,
    OP_SUB  = 4'h1,
    OP_AND  = 4'h2,
    OP_OR   = 4'h3,
    OP_XOR  = 4'h4,
    OP_NOT  = 4'h5,
    OP_SLL  = 4'h6,
    OP_SRL  = 4'h7,
    OP_SLT  = 4'h8,
    OP_MUL  = 4'h9,
    OP_INC  = 4'hA,
    OP_DEC  = 4'hB,
    OP_SRA  = 4'hC,
    OP_DIVU = 4'hD,
    OP_REMU = 4'hE,
    OP_SLTS = 4'hF
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } alu_state_e;

  typedef struct packed {
    logic zero;
    logic carry;
    logic overflow;
    logic dbz;
  } alu_flags_t;

  // Operations that go through the shared iterative unit.
  function automatic logic is_iter_op(alu_op_e op);
    return (op == OP_MUL) || (op == OP_DIVU) || (op == OP_REMU);
  endfunction

endpackage

// File: rtl/alu_iter_unit.sv
// Shared iterative datapath: shift-add multiplier and restoring divider.
// Both algorithms use one {hi, lo} register pair and run exactly DATA_WIDTH
// steps, so latency never depends on operand values (including b = 0).
module alu_iter_unit
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  alu_op_e               op,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  high_nonzero,
  output logic                  dbz
);

  localparam int W     = DATA_WIDTH;
  localparam int CNT_W = $clog2(DATA_WIDTH) + 1;

  logic             running;
  logic [CNT_W-1:0] cnt;
  alu_op_e          op_r;
  logic [W-1:0]     hi;
  logic [W-1:0]     lo;
  logic [W-1:0]     dvs;

  logic [W-1:0]     hi_n;
  logic [W-1:0]     lo_n;
  logic [W:0]       sum;
  logic [W:0]       shifted;
  logic [W:0]       diff;

  // One algorithm step. MUL: lo holds the multiplier, hi the partial product.
  // DIV: lo holds the dividend shifting into hi (the remainder) while quotient
  // bits shift in from the right. With a zero divisor the trial subtract never
  // borrows, so the quotient fills with ones and hi ends up holding a.
  always_comb begin
    sum     = {1'b0, hi} + (lo[0] ? {1'b0, dvs} : '0);
    shifted = {hi, lo[W-1]};
    diff    = shifted - {1'b0, dvs};
    hi_n    = hi;
    lo_n    = lo;
    if (op_r == OP_MUL) begin
      hi_n = sum[W:1];
      lo_n = {sum[0], lo[W-1:1]};
    end else if (!diff[W]) begin
      hi_n = diff[W-1:0];
      lo_n = {lo[W-2:0], 1'b1};
    end else begin
      hi_n = shifted[W-1:0];
      lo_n = {lo[W-2:0], 1'b0};
    end
  end

  assign done         = running && (cnt == CNT_W'(W - 1));
  assign result       = (op_r == OP_REMU) ? hi_n : lo_n;
  assign high_nonzero = (op_r == OP_MUL) && (|hi_n);
  assign dbz          = (op_r != OP_MUL) && (dvs == '0);

  // Load operands on start, then advance one step per clock until the last.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      running <= 1'b0;
      cnt     <= '0;
      op_r    <= OP_MUL;
      hi      <= '0;
      lo      <= '0;
      dvs     <= '0;
    end else if (start) begin
      running <= 1'b1;
      cnt     <= '0;
      op_r    <= op;
      hi      <= '0;
      lo      <= a;
      dvs     <= b;
    end else if (running) begin
      hi  <= hi_n;
      lo  <= lo_n;
      cnt <= cnt + CNT_W'(1);
      if (done) running <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_mc.sv
// Registered multi-cycle ALU between decode and writeback.
// Handshake: a transfer happens on a clock edge where valid & ready are both
// high; a producer holds valid and its payload until that edge, and ready may
// depend combinationally on the other side's ready (in_ready = out_ready in
// DONE, so a result can retire and a new op enter on the same edge).
module alu_mc
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int OPCODE_WIDTH = 4,
  localparam int SHAMT_W     = $clog2(DATA_WIDTH)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_WIDTH-1:0]   a,
  input  logic [DATA_WIDTH-1:0]   b,
  input  logic [OPCODE_WIDTH-1:0] opcode,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_WIDTH-1:0]   result,
  output logic                    zero_flag,
  output logic                    carry_flag,
  output logic                    overflow_flag,
  output logic                    dbz_flag,
  output logic                    busy
);

  localparam int W = DATA_WIDTH;
  localparam int M = DATA_WIDTH - 1;
  localparam logic [W-1:0] MSB_ONLY = {1'b1, {(W-1){1'b0}}};

  alu_state_e          state, state_n;
  alu_op_e             op_in;
  logic [SHAMT_W-1:0]  shamt;
  logic [W-1:0]        result_r;
  alu_flags_t          flags_r;

  logic [W-1:0]        sc_result;
  logic                sc_carry;
  logic                sc_ovf;
  logic [W:0]          wide;
  logic signed [W-1:0] sra_v;

  logic                start;
  logic                load_sc;
  logic                load_iter;
  logic                it_done;
  logic [W-1:0]        it_result;
  logic                it_high_nz;
  logic                it_dbz;

  assign op_in = alu_op_e'(opcode);
  assign shamt = b[SHAMT_W-1:0];

  // Single-cycle datapath; iterative opcodes fall to the zero default.
  always_comb begin
    sc_result = '0;
    sc_carry  = 1'b0;
    sc_ovf    = 1'b0;
    wide      = '0;
    sra_v     = $signed(a) >>> shamt;
    case (op_in)
      OP_ADD: begin
        wide      = {1'b0, a} + {1'b0, b};
        sc_result = wide[W-1:0];
        sc_carry  = wide[W];
        sc_ovf    = (a[M] == b[M]) && (sc_result[M] != a[M]);
      end
      OP_SUB: begin
        wide      = {1'b0, a} - {1'b0, b};
        sc_result = wide[W-1:0];
        sc_carry  = wide[W];
        sc_ovf    = (a[M] != b[M]) && (sc_result[M] != a[M]);
      end
      OP_AND:  sc_result = a & b;
      OP_OR:   sc_result = a | b;
      OP_XOR:  sc_result = a ^ b;
      OP_NOT:  sc_result = ~a;
      OP_SLL:  sc_result = a << shamt;
      OP_SRL:  sc_result = a >> shamt;
      OP_SRA:  sc_result = sra_v;
      OP_SLT:  sc_result = W'(a < b);
      OP_SLTS: sc_result = W'($signed(a) < $signed(b));
      OP_INC: begin
        sc_result = a + W'(1);
        sc_carry  = &a;
        sc_ovf    = &a;
      end
      OP_DEC: begin
        sc_result = a - W'(1);
        sc_carry  = (a == '0);
        sc_ovf    = (a == MSB_ONLY);
      end
      default: ;
    endcase
  end

  // Accept on an idle slot or when the held result retires this same edge.
  always_comb begin
    state_n   = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    start     = 1'b0;
    load_sc   = 1'b0;
    load_iter = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (is_iter_op(op_in)) begin
            start   = 1'b1;
            state_n = EXEC;
          end else begin
            load_sc = 1'b1;
            state_n = DONE;
          end
        end
      end
      EXEC: begin
        busy = 1'b1;
        if (it_done) begin
          load_iter = 1'b1;
          state_n   = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
        if (out_ready) begin
          if (in_valid) begin
            if (is_iter_op(op_in)) begin
              start   = 1'b1;
              state_n = EXEC;
            end else begin
              load_sc = 1'b1;
              state_n = DONE;
            end
          end else begin
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  // Result and flag registers, loaded from whichever datapath finished.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_r <= '0;
      flags_r  <= '0;
    end else if (load_sc) begin
      result_r         <= sc_result;
      flags_r.zero     <= (sc_result == '0);
      flags_r.carry    <= sc_carry;
      flags_r.overflow <= sc_ovf;
      flags_r.dbz      <= 1'b0;
    end else if (load_iter) begin
      result_r         <= it_result;
      flags_r.zero     <= (it_result == '0);
      flags_r.carry    <= it_high_nz;
      flags_r.overflow <= 1'b0;
      flags_r.dbz      <= it_dbz;
    end
  end

  alu_iter_unit #(.DATA_WIDTH(DATA_WIDTH)) u_iter (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .op           (op_in),
    .a            (a),
    .b            (b),
    .done         (it_done),
    .result       (it_result),
    .high_nonzero (it_high_nz),
    .dbz          (it_dbz)
  );

  assign result        = result_r;
  assign zero_flag     = flags_r.zero;
  assign carry_flag    = flags_r.carry;
  assign overflow_flag = flags_r.overflow;
  assign dbz_flag      = flags_r.dbz;

endmodule

// File: tb/tb_alu_mc.sv
// Bench for alu_mc: directed cases, backpressure, mid-op reset, then random
// traffic, all checked by a monitor against an arithmetic reference model.
module tb_alu_mc;

  localparam int DW = 8;
  localparam longint MAXU = (longint'(1) << DW) - 1;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] a;
  logic [DW-1:0] b;
  logic [3:0]    opcode;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] result;
  logic          zero_flag;
  logic          carry_flag;
  logic          overflow_flag;
  logic          dbz_flag;
  logic          busy;

  typedef struct packed {
    logic [3:0]    op;
    logic [DW-1:0] result;
    logic          zero;
    logic          carry;
    logic          ovf;
    logic          dbz;
    int            cyc;
    int            lat;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  logic rand_ready = 1'b0;
  logic lat_done = 1'b0;

  alu_mc #(.DATA_WIDTH(DW), .OPCODE_WIDTH(4)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .a             (a),
    .b             (b),
    .opcode        (opcode),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .result        (result),
    .zero_flag     (zero_flag),
    .carry_flag    (carry_flag),
    .overflow_flag (overflow_flag),
    .dbz_flag      (dbz_flag),
    .busy          (busy)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Random consumer backpressure, changed away from both clock edges.
  always @(posedge clk) begin
    #2;
    if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
  end

  // ---------------- reference model ----------------
  function automatic exp_t model(input logic [3:0] op, input logic [DW-1:0] av,
                                 input logic [DW-1:0] bv);
    exp_t   e;
    longint ua   = longint'(av);
    longint ub   = longint'(bv);
    longint sa   = av[DW-1] ? ua - (longint'(1) << DW) : ua;
    longint sb   = bv[DW-1] ? ub - (longint'(1) << DW) : ub;
    longint smax = (longint'(1) << (DW - 1)) - 1;
    longint smin = -(longint'(1) << (DW - 1));
    longint sh   = ub % DW;
    longint r    = 0;
    longint t    = 0;
    e = '0;
    e.op = op;
    case (op)
      4'h0: begin r = ua + ub; e.carry = (r > MAXU); t = sa + sb; e.ovf = (t > smax) || (t < smin); end
      4'h1: begin r = ua - ub; e.carry = (ua < ub); t = sa - sb; e.ovf = (t > smax) || (t < smin); end
      4'h2: r = ua & ub;
      4'h3: r = ua | ub;
      4'h4: r = ua ^ ub;
      4'h5: r = MAXU - ua;
      4'h6: r = ua << sh;
      4'h7: r = ua >> sh;
      4'h8: r = (ua < ub) ? 1 : 0;
      4'h9: begin r = ua * ub; e.carry = ((r >> DW) != 0); end
      4'hA: begin r = ua + 1; e.carry = (ua == MAXU); e.ovf = (ua == MAXU); end
      4'hB: begin r = ua - 1; e.carry = (ua == 0); e.ovf = (ua == (longint'(1) << (DW - 1))); end
      4'hC: r = sa >>> sh;
      4'hD: begin r = (ub == 0) ? MAXU : ua / ub; e.dbz = (ub == 0); end
      4'hE: begin r = (ub == 0) ? ua : ua % ub; e.dbz = (ub == 0); end
      default: r = (sa < sb) ? 1 : 0;
    endcase
    r        = r & MAXU;
    e.result = DW'(r);
    e.zero   = (r == 0);
    e.lat    = (op == 4'h9 || op == 4'hD || op == 4'hE) ? DW + 1 : 1;
    return e;
  endfunction

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Entered at a falling edge; returns at the falling edge after acceptance.
  task automatic issue(input logic [3:0] op, input logic [DW-1:0] av,
                       input logic [DW-1:0] bv);
    exp_t e;
    int   n;
    in_valid = 1'b1;
    opcode   = op;
    a        = av;
    b        = bv;
    #1;
    n = 0;
    while (!in_ready && n < 300) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!in_ready) begin
      chk("accept_timeout", 0, 1);
      in_valid = 1'b0;
    end else begin
      e     = model(op, av, bv);
      e.cyc = cyc;
      exp_q.push_back(e);
      @(negedge clk);
      in_valid = 1'b0;
      opcode   = 4'($urandom_range(0, 15));
      a        = DW'($urandom);
      b        = DW'($urandom);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) chk("drain_timeout", exp_q.size(), 0);
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    #2;
    if (!rst_n) begin
      lat_done = 1'b0;
    end else if (out_valid) begin
      if (exp_q.size() == 0) begin
        chk("spurious_valid", exp_q.size(), 1);
      end else begin
        if (!lat_done) begin
          chk($sformatf("latency op%0h", exp_q[0].op), cyc - exp_q[0].cyc, exp_q[0].lat);
          lat_done = 1'b1;
        end
        if (out_ready) begin
          chk($sformatf("result op%0h", exp_q[0].op), result, exp_q[0].result);
          chk($sformatf("zero op%0h", exp_q[0].op), zero_flag, exp_q[0].zero);
          chk($sformatf("carry op%0h", exp_q[0].op), carry_flag, exp_q[0].carry);
          chk($sformatf("ovf op%0h", exp_q[0].op), overflow_flag, exp_q[0].ovf);
          chk($sformatf("dbz op%0h", exp_q[0].op), dbz_flag, exp_q[0].dbz);
          void'(exp_q.pop_front());
          lat_done = 1'b0;
        end
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #2000000;
    chk("watchdog", 0, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // ---------------- stimulus ----------------
  initial begin
    int n;
    logic [3:0] rop;
    logic [DW-1:0] ra, rb;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    opcode    = '0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst out_valid", out_valid, 0);
    chk("rst busy", busy, 0);
    chk("rst result", result, 0);
    chk("rst flags", {zero_flag, carry_flag, overflow_flag, dbz_flag}, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst in_ready", in_ready, 1);
    chk("post_rst out_valid", out_valid, 0);

    // Directed cases from the plan.
    issue(4'h0, 8'hFF, 8'h01);
    issue(4'h0, 8'h7F, 8'h01);
    drain();
    issue(4'h9, 8'h10, 8'h10);
    n = 0;
    while (busy && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("mul busy cycles", n, DW);
    drain();
    issue(4'h9, 8'h0C, 8'h0B);
    issue(4'hD, 8'd200, 8'd7);
    issue(4'hE, 8'd200, 8'd7);
    issue(4'hD, 8'h05, 8'h00);
    issue(4'hE, 8'h05, 8'h00);
    issue(4'hC, 8'h80, 8'h03);
    issue(4'h7, 8'h80, 8'h03);
    issue(4'hF, 8'h80, 8'h01);
    issue(4'h8, 8'h80, 8'h01);
    issue(4'h6, 8'h81, 8'h0B);
    issue(4'hB, 8'h80, 8'h00);
    issue(4'hB, 8'h00, 8'h00);
    drain();

    // Backpressure, then retire-and-accept on the same edge.
    out_ready = 1'b0;
    issue(4'h1, 8'h03, 8'h05);
    for (int i = 0; i < 3; i++) begin
      chk("bp result", result, 8'hFE);
      chk("bp carry", carry_flag, 1);
      chk("bp in_ready", in_ready, 0);
      chk("bp out_valid", out_valid, 1);
      @(negedge clk);
    end
    out_ready = 1'b1;
    issue(4'hA, 8'hFF, 8'h00);
    drain();

    // Reset during the fourth EXEC cycle of a MUL.
    issue(4'h9, 8'h37, 8'h5A);
    repeat (3) @(negedge clk);
    chk("mid busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst out_valid", out_valid, 0);
    chk("mid_rst busy", busy, 0);
    chk("mid_rst flags", {zero_flag, carry_flag, overflow_flag, dbz_flag}, 0);
    chk("mid_rst result", result, 0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("after_rst in_ready", in_ready, 1);
    issue(4'h0, 8'h12, 8'h34);
    drain();

    // Random traffic with random backpressure.
    rand_ready = 1'b1;
    for (int i = 0; i < 200; i++) begin
      rop = 4'($urandom_range(0, 15));
      ra  = DW'($urandom);
      rb  = ($urandom_range(0, 7) == 0) ? '0 : DW'($urandom);
      issue(rop, ra, rb);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    rand_ready = 1'b0;
    @(negedge clk);
    out_ready = 1'b1;
    drain();
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_mc.md
Name: alu_mc

Overview:
- Registered, multi-cycle, parametrised successor to the team's combinational 8-bit ALU.
- Keeps the 12 existing opcodes and their flag semantics, and adds SRA, unsigned divide, unsigned remainder and signed set-less-than.
- Single-cycle ops complete in one clock. MUL, DIVU and REMU run on an iterative unit.
- Sits between the decode stage and the writeback stage, with valid/ready handshakes on both sides.

Parameters:
- DATA_WIDTH, 8, operand/result width (>=4, power of two).
- OPCODE_WIDTH, 4, opcode width (fixed at 4; all 16 codes are defined).
- SHAMT_W, $clog2(DATA_WIDTH), number of low bits of b used as the shift amount (derived, not user-set).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operation request.
- in_ready  out  1  block can accept a request this cycle.
- a  in  DATA_WIDTH  operand A.
- b  in  DATA_WIDTH  operand B.
- opcode  in  OPCODE_WIDTH  operation select.
- out_valid  out  1  result and flags valid.
- out_ready  in  1  consumer accepts the result.
- result  out  DATA_WIDTH  registered result.
- zero_flag  out  1  result == 0.
- carry_flag  out  1  carry / borrow / MUL high-half nonzero.
- overflow_flag  out  1  signed overflow.
- dbz_flag  out  1  divide by zero (DIVU/REMU only).
- busy  out  1  iterative operation in progress.

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-low, rst_n.
- Reset values: state=IDLE; out_valid, busy and all flags 0; result 0; in_ready 1 after reset releases.
- Opcodes:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOT, 6 SLL, 7 SRL.
  - 8 SLT (unsigned), 9 MUL (low half), A INC, B DEC.
  - C SRA, D DIVU, E DIVU-remainder (REMU), F SLTS (signed).
- Flags, unchanged from the existing ALU:
  - ADD: carry = bit DATA_WIDTH of the sum; overflow = same-sign operands giving a different-sign result.
  - SUB: carry = (a<b); overflow = differing-sign operands and result sign != a sign.
  - INC: carry = wrap; overflow when a = all ones.
  - DEC: carry when a = 0; overflow when a = MSB-only.
  - MUL: carry = |high half of the product.
  - All other ops: carry = 0, overflow = 0.
  - zero_flag is always (result == 0).
- Shifts: amount = b[SHAMT_W-1:0]. SRA replicates a[MSB].
- FSM states:
  - IDLE: in_ready=1. On accept (in_valid & in_ready), single-cycle ops compute and register the result, then go to DONE. MUL/DIVU/REMU load the iterative unit and go to EXEC.
  - EXEC: busy=1, in_ready=0. A counter runs DATA_WIDTH iterations (shift-add multiply, restoring divide). At count DATA_WIDTH-1, register the result and flags, then go to DONE.
  - DONE: out_valid=1; result and flags held stable while out_ready=0.
    - out_ready=1 and in_valid=0: go to IDLE.
    - in_ready = out_ready in this state. A simultaneous out_ready & in_valid retires the current result and accepts the new op in the same cycle (back-to-back, no bubble).
- Latency, measured from the accepting edge to the edge where out_valid rises:
  - Single-cycle ops: 1 cycle.
  - MUL, DIVU, REMU: DATA_WIDTH+1 cycles, fixed regardless of operand values.
- Divide by zero (b=0): still takes the full DATA_WIDTH+1 latency. DIVU result = all ones; REMU result = a; dbz_flag=1; carry and overflow 0.
- Operands and opcode are captured at accept. Input changes afterwards have no effect.
- Reset mid-EXEC or mid-DONE: the operation is abandoned and the result is lost. Outputs return to reset values immediately (asynchronous).
- No X on outputs for any opcode; every code is defined.

Decomposition:
- alu_pkg holds:
  - alu_op_e, the 4-bit opcode enum listing all 16 values above.
  - alu_state_e (IDLE, EXEC, DONE).
  - an alu_flags_t struct {zero, carry, overflow, dbz}.
- One sub-module, alu_iter_unit, holds the shared shift-add multiplier and restoring divider.
  - Interface: start, op, a, b, done, result, high-nonzero, dbz.
  - Counter width is $clog2(DATA_WIDTH)+1.

Test Plan:
- ADD a=0xFF b=0x01 -> result 0x00, zero=1, carry=1, overflow=0; out_valid exactly 1 cycle after accept. ADD 0x7F+0x01 -> 0x80, overflow=1.
- MUL 0x10*0x10 -> result 0x00, carry=1, zero=1, out_valid exactly 9 cycles after accept, busy=1 for 8 cycles. MUL 0x0C*0x0B -> 0x84, carry=0.
- DIVU 200/7 -> 0x1C. REMU 200/7 -> 0x04. DIVU 5/0 -> 0xFF with dbz=1. REMU 5/0 -> 0x05 with dbz=1, after the same 9-cycle latency.
- SRA 0x80 by b=3 -> 0xF0. SRL 0x80 by 3 -> 0x10. SLTS 0x80 vs 0x01 -> 1. SLT 0x80 vs 0x01 -> 0. SLL by b=0x0B uses amount 3.
- Backpressure: hold out_ready=0 for 3 cycles after a SUB 0x03-0x05 -> result 0xFE and carry=1 stay stable, in_ready=0. Then out_ready=1 with in_valid=1 (INC 0xFF) -> next result 0x00, carry=1, overflow=1 one cycle later, with no bubble.
- Reset: assert rst_n=0 in the 4th EXEC cycle of a MUL -> out_valid, busy and flags 0 immediately. After release, in_ready=1 and a new ADD completes normally.
